// File: rtl/l4_parser_pkg.sv
// Shared types and constants for the L4 (TCP/UDP) header parser.
package l4_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPTS,
        PAYLOAD,
        SKIP
    } state_e;

    typedef enum logic [3:0] {
        F_NONE,
        F_SRC,
        F_DST,
        F_SEQ,
        F_ACK,
        F_OFF,
        F_FLAGS,
        F_WIN,
        F_CSUM,
        F_URG,
        F_ULEN
    } field_sel_e;

    localparam logic [7:0] PROTO_TCP     = 8'd6;
    localparam logic [7:0] PROTO_UDP     = 8'd17;
    localparam int         TCP_FIXED_LEN = 20;
    localparam int         UDP_LEN       = 8;

    localparam int TCP_FLAG_FIN = 0;
    localparam int TCP_FLAG_SYN = 1;
    localparam int TCP_FLAG_RST = 2;
    localparam int TCP_FLAG_PSH = 3;
    localparam int TCP_FLAG_ACK = 4;
    localparam int TCP_FLAG_URG = 5;
    localparam int TCP_FLAG_ECE = 6;
    localparam int TCP_FLAG_CWR = 7;
    localparam int TCP_FLAG_NS  = 8;

    // Which header field a given header byte offset belongs to.
    function automatic field_sel_e lane_field(input logic tcp, input logic [7:0] b);
        lane_field = F_NONE;
        if (tcp) begin
            if (b < 8'd2)       lane_field = F_SRC;
            else if (b < 8'd4)  lane_field = F_DST;
            else if (b < 8'd8)  lane_field = F_SEQ;
            else if (b < 8'd12) lane_field = F_ACK;
            else if (b == 8'd12) lane_field = F_OFF;
            else if (b == 8'd13) lane_field = F_FLAGS;
            else if (b < 8'd16) lane_field = F_WIN;
            else if (b < 8'd18) lane_field = F_CSUM;
            else if (b < 8'd20) lane_field = F_URG;
        end else begin
            if (b < 8'd2)      lane_field = F_SRC;
            else if (b < 8'd4) lane_field = F_DST;
            else if (b < 8'd6) lane_field = F_ULEN;
            else if (b < 8'd8) lane_field = F_CSUM;
        end
    endfunction

endpackage

// File: rtl/l4_byte_lane_map.sv
// Maps each byte lane of a beat to its header offset, field and big-endian byte position.
module l4_byte_lane_map
    import l4_parser_pkg::*;
#(
    parameter int NB = 8,
    parameter int IW = 4
) (
    input  logic [7:0]    start_cnt,
    input  logic [IW-1:0] idx_in,
    input  logic          is_tcp,
    output logic [NB-1:0] lane_valid,
    output field_sel_e    lane_sel [NB],
    output logic [1:0]    lane_pos [NB]
);

    logic [7:0] lane_idx [NB];

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            lane_valid[i] = (32'(idx_in) > i);
            lane_idx[i]   = start_cnt + 8'(i);
            lane_sel[i]   = lane_field(is_tcp, lane_idx[i]);
            // 32-bit fields start on 4-byte boundaries, 16-bit fields on even offsets
            lane_pos[i]   = (lane_sel[i] == F_SEQ || lane_sel[i] == F_ACK) ?
                            lane_idx[i][1:0] : {1'b0, lane_idx[i][0]};
        end
    end

endmodule

// File: rtl/l4_header_parser.sv
// Streaming TCP/UDP header parser: extracts L4 header fields byte-serially from
// beats following an IPv4 header, skips TCP options and counts payload bytes.
module l4_header_parser
    import l4_parser_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_OPT_BYTES = 40
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DATA_WIDTH-1:0]                tdata_in,
    input  logic [$clog2(DATA_WIDTH/8+1)-1:0]    idx_in,
    input  logic                                 data_valid_in,
    input  logic                                 last_flag_in,
    input  logic                                 l3_done_in,
    input  logic [7:0]                           protocol_in,
    output logic                                 hdr_valid,
    output logic                                 is_tcp,
    output logic                                 is_udp,
    output logic [15:0]                          src_port,
    output logic [15:0]                          dst_port,
    output logic [15:0]                          udp_length,
    output logic [15:0]                          checksum,
    output logic [15:0]                          tcp_window,
    output logic [15:0]                          tcp_urgent,
    output logic [31:0]                          tcp_seq,
    output logic [31:0]                          tcp_ack,
    output logic [3:0]                           tcp_data_offset,
    output logic [8:0]                           tcp_flags,
    output logic [5:0]                           tcp_opt_len,
    output logic                                 frame_done,
    output logic [15:0]                          payload_len,
    output logic                                 err_truncated,
    output logic                                 err_bad_offset,
    output logic                                 err_unsupported
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(NB + 1);

    state_e      state, state_nxt;
    logic [7:0]  hdr_cnt, hdr_cnt_nxt, proto_q;
    logic [15:0] pay_cnt, pay_cnt_nxt, pay_sum;
    logic [16:0] pay_wide;
    logic [7:0]  beat_bytes, start_cnt, end_cnt, hdr_total, fixed_len, pay_add, cur_proto;
    logic        cur_tcp, cur_sup, start_frame, hdr_beat, bad_off;
    logic [3:0]  doff_now;
    logic [5:0]  opt_now, opt_len_nxt;
    int          opt_int;
    logic        hdr_pulse, bad_pulse, unsup_pulse, trunc_pulse, done_pulse;

    logic [NB-1:0] lane_valid;
    field_sel_e    lane_sel [NB];
    logic [1:0]    lane_pos [NB];

    l4_byte_lane_map #(.NB(NB), .IW(IW)) u_lane_map (
        .start_cnt  (start_cnt),
        .idx_in     (idx_in),
        .is_tcp     (cur_tcp),
        .lane_valid (lane_valid),
        .lane_sel   (lane_sel),
        .lane_pos   (lane_pos)
    );

    // Per-beat decode: header progress, option/payload split, error and pulse decisions.
    always_comb begin
        beat_bytes  = (32'(idx_in) > NB) ? 8'(NB) : 8'(idx_in);
        cur_proto   = (state == IDLE) ? protocol_in : proto_q;
        cur_tcp     = (cur_proto == PROTO_TCP);
        cur_sup     = cur_tcp || (cur_proto == PROTO_UDP);
        start_frame = data_valid_in && (state == IDLE) && l3_done_in && (idx_in != '0);
        hdr_beat    = data_valid_in && (idx_in != '0) &&
                      ((start_frame && cur_sup) || state == HDR || state == OPTS);
        start_cnt   = (state == IDLE) ? 8'd0 : hdr_cnt;

        // Data offset may arrive in the same beat that completes the fixed header
        doff_now = tcp_data_offset;
        for (int i = 0; i < NB; i++) begin
            if (lane_valid[i] && lane_sel[i] == F_OFF)
                doff_now = tdata_in[8*i+4 +: 4];
        end
        opt_int   = (int'(doff_now) - 5) * 4;
        bad_off   = (doff_now < 4'd5) || (opt_int > MAX_OPT_BYTES);
        opt_now   = bad_off ? 6'd0 : 6'(opt_int);
        fixed_len = cur_tcp ? 8'(TCP_FIXED_LEN) : 8'(UDP_LEN);
        hdr_total = cur_tcp ? 8'(TCP_FIXED_LEN) + 8'(opt_now) : 8'(UDP_LEN);
        end_cnt   = start_cnt + beat_bytes;

        state_nxt   = state;
        hdr_cnt_nxt = hdr_cnt;
        pay_add     = 8'd0;
        opt_len_nxt = tcp_opt_len;
        hdr_pulse   = 1'b0;
        bad_pulse   = 1'b0;
        unsup_pulse = 1'b0;
        trunc_pulse = 1'b0;
        done_pulse  = 1'b0;

        if (start_frame && !cur_sup) begin
            unsup_pulse = 1'b1;
            state_nxt   = SKIP;
        end

        if (hdr_beat) begin
            if (cur_tcp && end_cnt >= fixed_len && bad_off) begin
                hdr_pulse   = 1'b1;
                bad_pulse   = 1'b1;
                opt_len_nxt = 6'd0;
                hdr_cnt_nxt = fixed_len;
                state_nxt   = SKIP;
            end else if (end_cnt >= hdr_total) begin
                hdr_pulse   = 1'b1;
                opt_len_nxt = cur_tcp ? opt_now : 6'd0;
                pay_add     = end_cnt - hdr_total;
                hdr_cnt_nxt = hdr_total;
                state_nxt   = PAYLOAD;
            end else begin
                hdr_cnt_nxt = end_cnt;
                state_nxt   = (end_cnt >= fixed_len) ? OPTS : HDR;
            end
        end else if (data_valid_in && state == PAYLOAD) begin
            pay_add = beat_bytes;
        end

        pay_wide    = {1'b0, pay_cnt} + 17'(pay_add);
        pay_sum     = pay_wide[16] ? 16'hFFFF : pay_wide[15:0];
        pay_cnt_nxt = pay_sum;

        if (data_valid_in && last_flag_in) begin
            done_pulse  = 1'b1;
            trunc_pulse = (state == HDR || state == OPTS || (start_frame && cur_sup)) && !hdr_pulse;
            state_nxt   = IDLE;
            hdr_cnt_nxt = 8'd0;
            pay_cnt_nxt = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            hdr_cnt         <= '0;
            pay_cnt         <= '0;
            proto_q         <= '0;
            hdr_valid       <= 1'b0;
            is_tcp          <= 1'b0;
            is_udp          <= 1'b0;
            src_port        <= '0;
            dst_port        <= '0;
            udp_length      <= '0;
            checksum        <= '0;
            tcp_window      <= '0;
            tcp_urgent      <= '0;
            tcp_seq         <= '0;
            tcp_ack         <= '0;
            tcp_data_offset <= '0;
            tcp_flags       <= '0;
            tcp_opt_len     <= '0;
            frame_done      <= 1'b0;
            payload_len     <= '0;
            err_truncated   <= 1'b0;
            err_bad_offset  <= 1'b0;
            err_unsupported <= 1'b0;
        end else begin
            state           <= state_nxt;
            hdr_cnt         <= hdr_cnt_nxt;
            pay_cnt         <= pay_cnt_nxt;
            hdr_valid       <= hdr_pulse;
            frame_done      <= done_pulse;
            err_truncated   <= trunc_pulse;
            err_bad_offset  <= bad_pulse;
            err_unsupported <= unsup_pulse;
            tcp_opt_len     <= opt_len_nxt;
            if (done_pulse)
                payload_len <= pay_sum;
            if (start_frame) begin
                proto_q <= protocol_in;
                is_tcp  <= (protocol_in == PROTO_TCP);
                is_udp  <= (protocol_in == PROTO_UDP);
            end
            // Bytes are big-endian: byte position 0 lands in the most significant byte
            if (hdr_beat) begin
                for (int i = 0; i < NB; i++) begin
                    if (lane_valid[i]) begin
                        case (lane_sel[i])
                            F_SRC:   src_port[8*(1-int'(lane_pos[i])) +: 8]   <= tdata_in[8*i +: 8];
                            F_DST:   dst_port[8*(1-int'(lane_pos[i])) +: 8]   <= tdata_in[8*i +: 8];
                            F_ULEN:  udp_length[8*(1-int'(lane_pos[i])) +: 8] <= tdata_in[8*i +: 8];
                            F_CSUM:  checksum[8*(1-int'(lane_pos[i])) +: 8]   <= tdata_in[8*i +: 8];
                            F_WIN:   tcp_window[8*(1-int'(lane_pos[i])) +: 8] <= tdata_in[8*i +: 8];
                            F_URG:   tcp_urgent[8*(1-int'(lane_pos[i])) +: 8] <= tdata_in[8*i +: 8];
                            F_SEQ:   tcp_seq[8*(3-int'(lane_pos[i])) +: 8]    <= tdata_in[8*i +: 8];
                            F_ACK:   tcp_ack[8*(3-int'(lane_pos[i])) +: 8]    <= tdata_in[8*i +: 8];
                            F_OFF: begin
                                tcp_data_offset         <= tdata_in[8*i+4 +: 4];
                                tcp_flags[TCP_FLAG_NS]  <= tdata_in[8*i];
                            end
                            F_FLAGS: tcp_flags[7:0] <= tdata_in[8*i +: 8];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_l4_header_parser.sv
// Directed self-checking bench for l4_header_parser (64-bit beats).
module tb_l4_header_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tdata_in;
    logic [3:0]  idx_in;
    logic        data_valid_in, last_flag_in, l3_done_in;
    logic [7:0]  protocol_in;
    logic        hdr_valid, is_tcp, is_udp;
    logic [15:0] src_port, dst_port, udp_length, checksum, tcp_window, tcp_urgent;
    logic [31:0] tcp_seq, tcp_ack;
    logic [3:0]  tcp_data_offset;
    logic [8:0]  tcp_flags;
    logic [5:0]  tcp_opt_len;
    logic        frame_done;
    logic [15:0] payload_len;
    logic        err_truncated, err_bad_offset, err_unsupported;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] fb [0:63];

    always #5 clk = ~clk;

    l4_header_parser dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tdata_in        (tdata_in),
        .idx_in          (idx_in),
        .data_valid_in   (data_valid_in),
        .last_flag_in    (last_flag_in),
        .l3_done_in      (l3_done_in),
        .protocol_in     (protocol_in),
        .hdr_valid       (hdr_valid),
        .is_tcp          (is_tcp),
        .is_udp          (is_udp),
        .src_port        (src_port),
        .dst_port        (dst_port),
        .udp_length      (udp_length),
        .checksum        (checksum),
        .tcp_window      (tcp_window),
        .tcp_urgent      (tcp_urgent),
        .tcp_seq         (tcp_seq),
        .tcp_ack         (tcp_ack),
        .tcp_data_offset (tcp_data_offset),
        .tcp_flags       (tcp_flags),
        .tcp_opt_len     (tcp_opt_len),
        .frame_done      (frame_done),
        .payload_len     (payload_len),
        .err_truncated   (err_truncated),
        .err_bad_offset  (err_bad_offset),
        .err_unsupported (err_unsupported)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse vector order: {hdr_valid, frame_done, err_truncated, err_bad_offset, err_unsupported}
    task automatic check_pulses(input string tag, input logic [4:0] expected);
        check_output(tag, 64'({hdr_valid, frame_done, err_truncated, err_bad_offset, err_unsupported}),
                     64'(expected));
    endtask

    // Drives one valid beat built from fb[first +: n] and samples just after the clock edge.
    task automatic apply_stimulus(input int first, input int n, input logic [7:0] proto, input logic last);
        @(negedge clk);
        tdata_in = '0;
        for (int i = 0; i < n; i++) tdata_in[8*i +: 8] = fb[first + i];
        idx_in        = 4'(n);
        data_valid_in = 1'b1;
        last_flag_in  = last;
        l3_done_in    = 1'b1;
        protocol_in   = proto;
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
        last_flag_in  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        data_valid_in = 1'b0;
        last_flag_in  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic put16(input int pos, input logic [15:0] v);
        fb[pos]     = v[15:8];
        fb[pos + 1] = v[7:0];
    endtask

    task automatic put32(input int pos, input logic [31:0] v);
        put16(pos, v[31:16]);
        put16(pos + 2, v[15:0]);
    endtask

    initial begin
        rst_n = 1'b0; tdata_in = '0; idx_in = '0; data_valid_in = 1'b0;
        last_flag_in = 1'b0; l3_done_in = 1'b0; protocol_in = '0;
        for (int i = 0; i < 64; i++) fb[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_pulses("reset_pulses", 5'b00000);
        check_output("reset_fields", {src_port, dst_port, udp_length, checksum}, 64'h0);
        check_output("reset_tcp", {tcp_seq, tcp_ack}, 64'h0);
        check_output("reset_misc", {is_tcp, is_udp, tcp_opt_len, payload_len}, 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // UDP: 8-byte header in one beat, empty beat, then 8 payload bytes with last
        put16(0, 16'h1234); put16(2, 16'h0035); put16(4, 16'h0010); put16(6, 16'hBEEF);
        for (int i = 8; i < 16; i++) fb[i] = 8'h50 + 8'(i);
        apply_stimulus(0, 8, 8'd17, 1'b0);
        check_pulses("udp_hdr_pulse", 5'b10000);
        check_output("udp_ports", {src_port, dst_port}, 64'h1234_0035);
        check_output("udp_len_csum", {udp_length, checksum}, 64'h0010_BEEF);
        check_output("udp_class", {is_tcp, is_udp}, 64'b01);
        apply_stimulus(8, 0, 8'd17, 1'b0);
        check_pulses("udp_empty_beat", 5'b00000);
        apply_stimulus(8, 8, 8'd17, 1'b1);
        check_pulses("udp_done_pulse", 5'b01000);
        check_output("udp_payload_len", payload_len, 64'd8);

        // TCP, data offset 8 (12 option bytes), 3-byte beats, 4 payload bytes
        put16(0, 16'h0400); put16(2, 16'h0050); put32(4, 32'h11223344); put32(8, 32'h55667788);
        fb[12] = 8'h80; fb[13] = 8'h18; put16(14, 16'h7210); put16(16, 16'hABCD); put16(18, 16'h0001);
        for (int i = 20; i < 32; i++) fb[i] = 8'h01;
        for (int i = 32; i < 36; i++) fb[i] = 8'hA0 + 8'(i);
        for (int b = 0; b < 12; b++) begin
            apply_stimulus(3*b, 3, 8'd6, b == 11);
            check_output("tcp_hdr_valid_beat", 64'(hdr_valid), 64'(b == 10));
            if (b == 5) begin
                idle_cycle();
                check_pulses("tcp_stall", 5'b00000);
            end
        end
        check_pulses("tcp_done_pulse", 5'b01000);
        check_output("tcp_payload_len", payload_len, 64'd4);
        check_output("tcp_ports", {src_port, dst_port}, 64'h0400_0050);
        check_output("tcp_seq_ack", {tcp_seq, tcp_ack}, 64'h11223344_55667788);
        check_output("tcp_off_flags_opt", {tcp_data_offset, tcp_flags, tcp_opt_len}, {45'h0, 4'd8, 9'h018, 6'd12});
        check_output("tcp_win_csum_urg", {tcp_window, checksum, tcp_urgent}, 64'h7210_ABCD_0001);
        check_output("tcp_class", {is_tcp, is_udp}, 64'b10);

        // TCP with data offset 3: bad offset flagged with hdr_valid, rest skipped
        for (int i = 0; i < 32; i++) fb[i] = 8'h00;
        put16(0, 16'h1111); put16(2, 16'h2222); fb[12] = 8'h30; fb[13] = 8'h02;
        apply_stimulus(0, 8, 8'd6, 1'b0);
        check_pulses("bad_beat0", 5'b00000);
        apply_stimulus(8, 8, 8'd6, 1'b0);
        check_pulses("bad_beat1", 5'b00000);
        apply_stimulus(16, 8, 8'd6, 1'b0);
        check_pulses("bad_offset_pulse", 5'b10010);
        check_output("bad_opt_len", {tcp_data_offset, tcp_opt_len}, {54'h0, 4'd3, 6'd0});
        apply_stimulus(24, 8, 8'd6, 1'b1);
        check_pulses("bad_done_pulse", 5'b01000);
        check_output("bad_payload_len", payload_len, 64'd0);

        // UDP truncated after 5 bytes, then a normal frame completing on its last beat
        put16(0, 16'hC001); put16(2, 16'h0007); put16(4, 16'h000C); put16(6, 16'h1111);
        for (int i = 8; i < 12; i++) fb[i] = 8'hEE;
        apply_stimulus(0, 5, 8'd17, 1'b1);
        check_pulses("trunc_pulse", 5'b01100);
        check_output("trunc_payload_len", payload_len, 64'd0);
        apply_stimulus(0, 6, 8'd17, 1'b0);
        check_pulses("after_trunc_beat0", 5'b00000);
        apply_stimulus(6, 6, 8'd17, 1'b1);
        check_pulses("hdr_and_done_same", 5'b11000);
        check_output("after_trunc_fields", {src_port, dst_port, udp_length, checksum}, 64'hC001_0007_000C_1111);
        check_output("after_trunc_payload", payload_len, 64'd4);

        // Unsupported protocol (ICMP)
        apply_stimulus(0, 8, 8'd1, 1'b0);
        check_pulses("icmp_unsup", 5'b00001);
        check_output("icmp_class", {is_tcp, is_udp}, 64'b00);
        apply_stimulus(8, 4, 8'd1, 1'b1);
        check_pulses("icmp_done", 5'b01000);
        check_output("icmp_payload_len", payload_len, 64'd0);

        // Reset in the middle of a TCP header, then a fresh UDP frame
        put16(0, 16'hDEAD); put16(2, 16'hBEEF); put32(4, 32'hCAFEF00D);
        apply_stimulus(0, 8, 8'd6, 1'b0);
        check_output("mid_tcp_seq", tcp_seq, 64'hCAFEF00D);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("midreset_fields", {src_port, tcp_seq[31:0], dst_port}, 64'h0);
        check_output("midreset_class", {is_tcp, is_udp, payload_len}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        idle_cycle();
        check_pulses("post_reset_quiet", 5'b00000);
        put16(0, 16'h0101); put16(2, 16'h0202); put16(4, 16'h000A); put16(6, 16'h3333);
        fb[8] = 8'h77; fb[9] = 8'h88;
        apply_stimulus(0, 8, 8'd17, 1'b0);
        check_pulses("post_reset_hdr", 5'b10000);
        check_output("post_reset_fields", {src_port, dst_port, udp_length, checksum}, 64'h0101_0202_000A_3333);
        check_output("post_reset_no_tcp", {tcp_seq, 30'h0, is_tcp, is_udp}, 64'h1);
        apply_stimulus(8, 2, 8'd17, 1'b1);
        check_pulses("post_reset_done", 5'b01000);
        check_output("post_reset_payload", payload_len, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l4_header_parser.md
L4_HEADER_PARSER -- requirements
Module: l4_header_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, stream beat width in bits (multiple of 8, 32..512).
REQ-002 SHALL have parameter MAX_OPT_BYTES, default 40, largest TCP option length accepted.
REQ-003 SHALL have ports: clk  in  1  sole clock. Reset is synchronous and active-low.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 tdata_in  in  DATA_WIDTH  L4 bytes; byte i is tdata_in[8i+7:8i], wire order.
REQ-006 idx_in  in  $clog2(DATA_WIDTH/8+1)  count of valid low-aligned bytes in beat.
REQ-007 data_valid_in  in  1  beat qualifier; last_flag_in  in  1  final beat of frame.
REQ-008 l3_done_in  in  1  IPv4 header consumed, beats carry L4 bytes; protocol_in  in  8  IPv4 protocol field.
REQ-009 hdr_valid  out  1  one-cycle pulse, header fields stable and complete.
REQ-010 is_tcp, is_udp  out  1 each  class of current header, held until next frame.
REQ-011 src_port, dst_port  out  16 each; udp_length, checksum, tcp_window, tcp_urgent  out  16 each.
REQ-012 tcp_seq, tcp_ack  out  32 each; tcp_data_offset  out  4; tcp_flags  out  9 (NS..FIN).
REQ-013 tcp_opt_len  out  6  option bytes skipped (bytes, 0..40).
REQ-014 frame_done  out  1  pulse on last beat; payload_len  out  16  L4 payload bytes, valid with frame_done.
REQ-015 err_truncated, err_bad_offset, err_unsupported  out  1 each  one-cycle error pulses.

Function
REQ-016 SHALL use FSM states IDLE, HDR, OPTS, PAYLOAD, SKIP.
REQ-017 IDLE: on data_valid_in && l3_done_in SHALL latch protocol_in; 6 -> HDR (TCP, 20 B), 17 -> HDR (UDP, 8 B), else -> SKIP and pulse err_unsupported; the same beat's bytes SHALL be consumed.
REQ-018 HDR: SHALL consume bytes 0..idx_in-1 in order per valid beat, writing big-endian fields by byte counter; any number of header bytes per beat (up to DATA_WIDTH/8) SHALL be handled in one cycle.
REQ-019 Bytes beyond fixed header in the same beat SHALL be counted as options (TCP) or payload (UDP).
REQ-020 UDP: after byte 7, hdr_valid SHALL pulse the cycle after that beat; FSM -> PAYLOAD.
REQ-021 TCP: after byte 19, opt = (data_offset-5)*4; opt==0 -> hdr_valid next cycle, -> PAYLOAD; opt>0 -> OPTS.
REQ-022 data_offset<5 or opt>MAX_OPT_BYTES SHALL pulse err_bad_offset with hdr_valid, set tcp_opt_len 0, -> SKIP.
REQ-023 OPTS: SHALL discard option bytes; when count reaches opt, pulse hdr_valid next cycle, tcp_opt_len=opt, remaining beat bytes count as payload.
REQ-024 PAYLOAD: SHALL add idx_in per valid beat to a 16-bit saturating payload counter.
REQ-025 last_flag_in with data_valid_in SHALL pulse frame_done next cycle with payload_len, FSM -> IDLE, from any state.
REQ-026 last in HDR/OPTS before completion SHALL pulse err_truncated and frame_done; hdr_valid SHALL NOT pulse.
REQ-027 Header completion and last in one beat SHALL pulse hdr_valid and frame_done in same cycle.
REQ-028 Beats with data_valid_in low SHALL change no state; idx_in==0 valid beats SHALL only honour last.
REQ-029 Field outputs SHALL hold value until overwritten by next frame's header bytes.

Reset
REQ-030 rst_n low at clk edge SHALL force FSM IDLE, all counters 0, all outputs 0, including mid-frame; no pulse SHALL follow reset release.

Structure
REQ-031 l4_parser_pkg SHALL hold: state enum, PROTO_TCP=6, PROTO_UDP=17, TCP_FIXED_LEN=20, UDP_LEN=8, tcp_flags bit indices.
REQ-032 Sub-module l4_byte_lane_map SHALL compute per-byte header index and field select for a beat from start counter and idx_in.

Verification
REQ-033 UDP, DATA_WIDTH=64: 8 B header 0x1234 0x0035 0x0010 0xBEEF + 8 B payload, last on beat 2 -> hdr_valid after beat 1, src 0x1234, dst 0x0035, frame_done payload_len 8.
REQ-034 TCP offset 8 (12 opt B), header split 3-byte beats -> hdr_valid once after option byte 31, tcp_opt_len 12, flags 0x018.
REQ-035 TCP offset 3 -> err_bad_offset + hdr_valid same cycle, then SKIP, frame_done payload_len 0.
REQ-036 UDP last after 5 header bytes -> err_truncated and frame_done, no hdr_valid; next frame parses normally.
REQ-037 Protocol 1 (ICMP) -> err_unsupported on first beat, no hdr_valid, frame_done on last.
REQ-038 rst_n low mid TCP header then new UDP frame -> correct UDP fields, no stale TCP values or pulses.
